// File: rtl/pipeline_buffer_if.sv
// Valid/ready handshake bundle for pipeline_buffer: producer side (i_*) and consumer side (o_*).
// The slave modport is the buffer's view; master is the surrounding datapath's view.
interface pipeline_buffer_if #(
    parameter int DATA_W = 256
);
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;

    modport slave (
        input  i_valid,
        input  i_data,
        input  o_ready,
        output i_ready,
        output o_valid,
        output o_data
    );

    modport master (
        output i_valid,
        output i_data,
        output o_ready,
        input  i_ready,
        input  o_valid,
        input  o_data
    );
endinterface

// File: rtl/pipeline_buffer.sv
// Elastic DEPTH-entry pipeline stage with first-word fall-through, synchronous flush and occupancy.
// Handshake outputs depend only on registered state, so no input-to-output combinational paths exist.
module pipeline_buffer #(
    parameter int  DATA_W = 256,
    parameter int  DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    pipeline_buffer_if.slave bus
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              clear;

    // Explicit wrap keeps non-power-of-two depths inside the storage array.
    function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.i_ready = (count != FULL_CNT);
    assign bus.o_valid = (count != '0);
    assign bus.o_data  = mem[rd_ptr];

    assign push  = bus.i_valid && bus.i_ready;
    assign pop   = bus.o_valid && bus.o_ready;
    assign clear = !rst || flush;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= advance(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= advance(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is deliberately not reset; a transfer during a clearing edge is discarded.
    always_ff @(posedge clk) begin
        if (!clear && push) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end
endmodule

// File: tb/tb_pipeline_buffer.sv
// Bench for pipeline_buffer at DEPTH 2, 3 and 1, each paired with a queue-based reference model.
// Directed scenarios run first, followed by a randomized phase with flushes and mid-run resets.
module tb_pipeline_buffer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         vld  [3];
    logic         ordy [3];
    logic         flsh [3];
    logic [W-1:0] din  [3];
    logic         rdy  [3];
    logic         ov   [3];
    logic [W-1:0] dout [3];
    logic [3:0]   cnt  [3];

    int checkCount = 0;
    int errCount   = 0;
    bit checking   = 1'b0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int D = (g == 0) ? 2 : ((g == 1) ? 3 : 1);

        logic [$clog2(D+1)-1:0] c;
        logic [W-1:0]           model  [$];
        logic [W-1:0]           popped [$];

        pipeline_buffer_if #(.DATA_W(W)) bus ();

        assign bus.i_valid = vld[g];
        assign bus.i_data  = din[g];
        assign bus.o_ready = ordy[g];
        assign rdy[g]      = bus.i_ready;
        assign ov[g]       = bus.o_valid;
        assign dout[g]     = bus.o_data;
        assign cnt[g]      = 4'(c);

        pipeline_buffer #(.DATA_W(W), .DEPTH(D)) dut (
            .clk   (clk),
            .rst   (rst),
            .flush (flsh[g]),
            .count (c),
            .bus   (bus.slave)
        );

        // Reference: an ordered list of stored words, accepting only when not full.
        always @(posedge clk) begin
            bit doPush;
            bit doPop;
            doPush = vld[g] && (model.size() < D);
            doPop  = ordy[g] && (model.size() > 0);
            if (ov[g] && ordy[g] && rst && !flsh[g]) popped.push_back(dout[g]);
            if (!rst || flsh[g]) begin
                model.delete();
            end else begin
                if (doPop) void'(model.pop_front());
                if (doPush) model.push_back(din[g]);
            end
        end

        always @(negedge clk) begin
            if (checking) begin
                checkOutput($sformatf("d%0d.count", D), 32'(cnt[g]), 32'(model.size()));
                checkOutput($sformatf("d%0d.o_valid", D), 32'(ov[g]), 32'(model.size() != 0));
                checkOutput($sformatf("d%0d.i_ready", D), 32'(rdy[g]), 32'(model.size() != D));
                if (model.size() > 0) checkOutput($sformatf("d%0d.o_data", D), dout[g], model[0]);
            end
        end
    end

    // Presents one word and holds it until accepted; waited reports edges spent.
    task automatic applyStimulus(input int idx, input logic [W-1:0] data, input bit randRdy, output int waited);
        bit r;
        bit done;
        vld[idx] = 1'b1;
        din[idx] = data;
        waited   = 0;
        done     = 1'b0;
        while (!done) begin
            if (randRdy) ordy[idx] = 1'($urandom_range(0, 1));
            r = rdy[idx];
            @(posedge clk);
            waited++;
            @(negedge clk);
            if (r) begin
                done = 1'b1;
            end else if (waited >= 50) begin
                checkOutput("push.timeout", 0, 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain(input int idx);
        int n;
        n = 0;
        ordy[idx] = 1'b1;
        while (ov[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (ov[idx]) checkOutput("drain.timeout", 1, 0);
    endtask

    initial begin
        int           w;
        int           nXfer;
        bit           prev;
        bit           r;
        logic [W-1:0] d;
        logic [W-1:0] sent [$];

        for (int i = 0; i < 3; i++) begin
            vld[i]  = 1'b1;
            din[i]  = $urandom;
            ordy[i] = 1'b0;
            flsh[i] = 1'b0;
        end

        // Reset held across two edges with traffic offered.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset.count", 32'(cnt[i]), 0);
            checkOutput("reset.o_valid", 32'(ov[i]), 0);
            checkOutput("reset.i_ready", 32'(rdy[i]), 1);
        end
        checking = 1'b1;
        @(negedge clk);

        // Streaming through DEPTH=2 with the consumer always ready.
        gen_dut[0].popped.delete();
        ordy[0] = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            applyStimulus(0, W'(v), 1'b0, w);
            checkOutput("stream.accept_wait", 32'(w), 1);
            checkOutput("stream.count_le1", 32'(cnt[0] <= 1), 1);
        end
        vld[0] = 1'b0;
        drain(0);
        checkOutput("stream.n", 32'(gen_dut[0].popped.size()), 8);
        for (int i = 0; i < gen_dut[0].popped.size() && i < 8; i++)
            checkOutput("stream.data", gen_dut[0].popped[i], W'(i + 1));

        // Back-pressure on DEPTH=3.
        gen_dut[1].popped.delete();
        ordy[1] = 1'b0;
        applyStimulus(1, 'hA, 1'b0, w);
        applyStimulus(1, 'hB, 1'b0, w);
        applyStimulus(1, 'hC, 1'b0, w);
        vld[1] = 1'b1;
        din[1] = 'hD;
        checkOutput("bp.i_ready_full", 32'(rdy[1]), 0);
        checkOutput("bp.count_full", 32'(cnt[1]), 3);
        @(negedge clk);
        checkOutput("bp.i_ready_hold", 32'(rdy[1]), 0);
        ordy[1] = 1'b1;
        applyStimulus(1, 'hD, 1'b0, w);
        checkOutput("bp.d_wait", 32'(w), 2);
        vld[1] = 1'b0;
        drain(1);
        checkOutput("bp.n", 32'(gen_dut[1].popped.size()), 4);
        for (int i = 0; i < gen_dut[1].popped.size() && i < 4; i++)
            checkOutput("bp.data", gen_dut[1].popped[i], W'('hA + i));

        // Pointer wrap on DEPTH=3 with a randomly stalling consumer.
        gen_dut[1].popped.delete();
        sent.delete();
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            sent.push_back(d);
            applyStimulus(1, d, 1'b1, w);
        end
        vld[1] = 1'b0;
        drain(1);
        checkOutput("wrap.n", 32'(gen_dut[1].popped.size()), 10);
        for (int i = 0; i < gen_dut[1].popped.size() && i < 10; i++)
            checkOutput("wrap.data", gen_dut[1].popped[i], sent[i]);

        // Flush with two entries held and a word offered in the same cycle.
        gen_dut[0].popped.delete();
        ordy[0] = 1'b0;
        applyStimulus(0, 'h5, 1'b0, w);
        applyStimulus(0, 'h6, 1'b0, w);
        checkOutput("flush.count_pre", 32'(cnt[0]), 2);
        vld[0]  = 1'b1;
        din[0]  = 'h7;
        flsh[0] = 1'b1;
        @(negedge clk);
        flsh[0] = 1'b0;
        vld[0]  = 1'b0;
        checkOutput("flush.count", 32'(cnt[0]), 0);
        checkOutput("flush.o_valid", 32'(ov[0]), 0);
        ordy[0] = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("flush.nothing_out", 32'(gen_dut[0].popped.size()), 0);

        // DEPTH=1 alternates acceptance under continuous traffic.
        ordy[2] = 1'b1;
        vld[2]  = 1'b1;
        din[2]  = $urandom;
        nXfer   = 0;
        prev    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            r = rdy[2];
            if (i > 0) checkOutput("d1.alternate", 32'(r), 32'(!prev));
            prev = r;
            @(posedge clk);
            @(negedge clk);
            if (r) begin
                nXfer++;
                din[2] = $urandom;
            end
        end
        checkOutput("d1.transfers", 32'(nXfer), 6);
        vld[2] = 1'b0;
        drain(2);

        // Randomized traffic on all depths, including flushes and mid-run resets.
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < 3; i++) begin
                vld[i]  = 1'($urandom_range(0, 1));
                din[i]  = $urandom;
                ordy[i] = ($urandom_range(0, 3) != 0);
                flsh[i] = ($urandom_range(0, 19) == 0);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld[i]  = 1'b0;
            flsh[i] = 1'b0;
            drain(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end
endmodule
